// File: rtl/vrased_pkg.sv
// vrased_pkg: shared FSM state type and memory-map constants for the reset sequencer.
package vrased_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        BOOT  = 2'd3
    } state_t;

    localparam logic [15:0] SMEM_BASE     = 16'hE000;
    localparam logic [15:0] SMEM_SIZE     = 16'h1000;
    localparam logic [15:0] RESET_HANDLER = 16'hFFFE;
    localparam logic [15:0] CLR_ADDR      = 16'h0190;

    // Offset compare keeps the upper bound from wrapping if SMEM ends at 16'hFFFF.
    function automatic logic in_smem(input logic [15:0] addr);
        logic [15:0] w_off;
        w_off = addr - SMEM_BASE;
        return (addr >= SMEM_BASE) && (w_off < SMEM_SIZE);
    endfunction
endpackage

// File: rtl/rst_hold_cnt.sv
// rst_hold_cnt: loadable up/down counter with zero flag; saturates instead of wrapping.
module rst_hold_cnt #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_up,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    logic         w_at_max;

    assign w_at_max = &r_cnt;
    assign o_cnt    = r_cnt;
    assign o_zero   = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= RST_VAL;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && i_up && !w_at_max)
            r_cnt <= r_cnt + 1'b1;
        else if (i_en && !i_up && !o_zero)
            r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ORs monitor reset requests, holds the MCU in reset, then waits for the
// reset-vector fetch; records cause, a saturating reset count and a sticky proof-of-reset flag.
module reset_sequencer
    import vrased_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int BOOT_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic [15:0]        pc,
    input  logic [15:0]        data_addr,
    input  logic               data_wr,
    output logic               cpu_rst,
    output logic [NUM_SRC:0]   cause,
    output logic [7:0]         rst_count,
    output logic               por_flag
);
    localparam int CW = $clog2((HOLD_CYCLES > BOOT_TIMEOUT ? HOLD_CYCLES : BOOT_TIMEOUT) + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_cpu_rst;
    logic [NUM_SRC:0] r_cause;
    logic [7:0]       r_rst_count;
    logic             r_por_flag;
    logic             w_req_any;
    logic             w_pc_hit;
    logic             w_timeout;
    logic             w_enter_hold;
    logic             w_clr;
    logic             w_cnt_load;
    logic [CW-1:0]    w_cnt_load_val;
    logic [CW-1:0]    w_cnt;
    logic             w_cnt_zero;

    assign w_req_any = |req;
    assign w_pc_hit  = (pc == RESET_HANDLER);
    assign w_timeout = (w_cnt == BOOT_LAST);
    assign w_clr     = data_wr && (data_addr == CLR_ADDR) && in_smem(pc);

    always_comb begin
        w_next       = r_state;
        w_enter_hold = 1'b0;
        case (r_state)
            RUN: begin
                w_next       = w_req_any ? HOLD : RUN;
                w_enter_hold = w_req_any;
            end
            HOLD:  w_next = w_cnt_zero ? (w_req_any ? DRAIN : BOOT) : HOLD;
            DRAIN: w_next = w_req_any ? DRAIN : BOOT;
            BOOT: begin
                w_next       = (w_req_any || (!w_pc_hit && w_timeout)) ? HOLD : (w_pc_hit ? RUN : BOOT);
                w_enter_hold = w_req_any || (!w_pc_hit && w_timeout);
            end
            default: w_next = HOLD;
        endcase
    end

    // One counter serves both phases: down-count through HOLD, up-count as the BOOT timer.
    assign w_cnt_load     = w_enter_hold || (w_next == BOOT && r_state != BOOT);
    assign w_cnt_load_val = w_enter_hold ? HOLD_LOAD : '0;

    rst_hold_cnt #(
        .W       (CW),
        .RST_VAL (HOLD_LOAD)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (r_state == HOLD || r_state == BOOT),
        .i_up       (r_state == BOOT),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HOLD;
            r_cpu_rst   <= 1'b1;
            r_cause     <= '0;
            r_rst_count <= 8'd0;
            r_por_flag  <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_cpu_rst <= (w_next == HOLD) || (w_next == DRAIN);
            // Only the BOOT timeout enters HOLD with req==0, so the MSB marks exactly that case.
            if (w_enter_hold)
                r_cause <= {~w_req_any, req};
            else if (r_state == HOLD || r_state == DRAIN)
                r_cause <= r_cause | {1'b0, req};
            if (w_enter_hold && r_rst_count != 8'hFF)
                r_rst_count <= r_rst_count + 8'd1;
            r_por_flag <= w_enter_hold ? 1'b1 : (w_clr ? 1'b0 : r_por_flag);
        end
    end

    assign cpu_rst   = r_cpu_rst;
    assign cause     = r_cause;
    assign rst_count = r_rst_count;
    assign por_flag  = r_por_flag;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and random stimulus against a behavioural model; a monitor
// process pops the expected outputs for every clock and compares them with the DUT.
module tb_reset_sequencer;
    localparam int NS           = 4;
    localparam int HOLD_CYCLES  = 8;
    localparam int BOOT_TIMEOUT = 64;
    localparam int PH_RUN = 0, PH_HOLD = 1, PH_DRAIN = 2, PH_BOOT = 3;

    typedef struct packed {
        logic          rst;
        logic [NS:0]   cause;
        logic [7:0]    cnt;
        logic          por;
    } exp_t;

    logic          clk = 1'b1;
    logic          reset = 1'b0;
    logic [NS-1:0] req = '0;
    logic [15:0]   pc = '0;
    logic [15:0]   data_addr = '0;
    logic          data_wr = 1'b0;
    logic          cpu_rst;
    logic [NS:0]   cause;
    logic [7:0]    rst_count;
    logic          por_flag;

    int n_chk = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    int          m_ph = PH_HOLD;
    int          m_hold = HOLD_CYCLES;
    int          m_age = 0;
    logic [NS:0] m_cause = '0;
    logic [7:0]  m_cnt = '0;
    logic        m_por = 1'b1;

    reset_sequencer #(
        .NUM_SRC      (NS),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .BOOT_TIMEOUT (BOOT_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .pc        (pc),
        .data_addr (data_addr),
        .data_wr   (data_wr),
        .cpu_rst   (cpu_rst),
        .cause     (cause),
        .rst_count (rst_count),
        .por_flag  (por_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: tracks remaining hold cycles and cycles spent waiting for the vector fetch.
    task automatic model(input logic r, input logic [NS-1:0] q, input logic [15:0] p,
                         input logic w, input logic [15:0] a);
        bit          enter;
        logic [NS:0] nc;
        enter = 0;
        nc = '0;
        if (r) begin
            m_ph = PH_HOLD; m_hold = HOLD_CYCLES; m_cause = '0; m_cnt = '0; m_por = 1'b1;
            return;
        end
        case (m_ph)
            PH_RUN: if (q != 0) begin enter = 1; nc = {1'b0, q}; end
            PH_HOLD: begin
                m_cause = m_cause | {1'b0, q};
                m_hold--;
                if (m_hold == 0) begin
                    if (q != 0) m_ph = PH_DRAIN;
                    else begin m_ph = PH_BOOT; m_age = 0; end
                end
            end
            PH_DRAIN: begin
                m_cause = m_cause | {1'b0, q};
                if (q == 0) begin m_ph = PH_BOOT; m_age = 0; end
            end
            default: begin
                if (q != 0) begin enter = 1; nc = {1'b0, q}; end
                else if (p == 16'hFFFE) m_ph = PH_RUN;
                else begin
                    m_age++;
                    if (m_age == BOOT_TIMEOUT) begin enter = 1; nc = '0; nc[NS] = 1'b1; end
                end
            end
        endcase
        if (enter) begin
            m_ph = PH_HOLD; m_hold = HOLD_CYCLES; m_cause = nc; m_por = 1'b1;
            m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
        end else if (w && a == 16'h0190 && p >= 16'hE000 && p <= 16'hEFFF)
            m_por = 1'b0;
    endtask

    task automatic cyc(input logic r, input logic [NS-1:0] q, input logic [15:0] p,
                       input logic w, input logic [15:0] a);
        exp_t e;
        @(negedge clk);
        reset = r; req = q; pc = p; data_wr = w; data_addr = a;
        model(r, q, p, w, a);
        e.rst = (m_ph == PH_HOLD) || (m_ph == PH_DRAIN);
        e.cause = m_cause;
        e.cnt = m_cnt;
        e.por = m_por;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 16'h0000, 0, 16'h0000);
    endtask

    task automatic to_run();
        for (int i = 0; i < 200 && m_ph != PH_RUN; i++) cyc(0, '0, 16'hFFFE, 0, 16'h0000);
        if (m_ph != PH_RUN) begin
            n_chk++; n_fail++;
            $display("FAIL to_run: bound expired, phase %0d required %0d", m_ph, PH_RUN);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cpu_rst", 32'(cpu_rst), 32'(e.rst));
                check("cause", 32'(cause), 32'(e.cause));
                check("rst_count", 32'(rst_count), 32'(e.cnt));
                check("por_flag", 32'(por_flag), 32'(e.por));
            end
        end
    end

    initial begin
        // Power-up: 8 cycles of reset, then vector fetch returns to RUN.
        cyc(1, '0, 16'h0000, 0, 16'h0000);
        idle(10);
        to_run();
        // Single-cycle request from RUN.
        cyc(0, 4'b0010, 16'h1234, 0, 16'h0000);
        idle(12);
        to_run();
        // Held request forces DRAIN; extra source pulsed during HOLD accumulates.
        cyc(0, 4'b0001, 16'h1000, 0, 16'h0000);
        cyc(0, 4'b0001, 16'h1000, 0, 16'h0000);
        cyc(0, 4'b0101, 16'h1000, 0, 16'h0000);
        for (int i = 0; i < 17; i++) cyc(0, 4'b0001, 16'h1000, 0, 16'h0000);
        idle(3);
        to_run();
        // BOOT timeout, twice in a row, then a late vector fetch.
        cyc(0, 4'b1000, 16'h2000, 0, 16'h0000);
        idle(160);
        to_run();
        // por_flag clear from inside / outside SMEM and at the region edges.
        cyc(0, '0, 16'hE010, 1, 16'h0190);
        @(posedge clk); #2;
        check("por_clear_smem", 32'(por_flag), 32'd0);
        cyc(0, 4'b0100, 16'h0000, 0, 16'h0000);
        idle(9);
        to_run();
        cyc(0, '0, 16'h4000, 1, 16'h0190);
        cyc(0, '0, 16'hF000, 1, 16'h0190);
        cyc(0, '0, 16'hDFFF, 1, 16'h0190);
        cyc(0, '0, 16'hEFFF, 1, 16'h0192);
        cyc(0, '0, 16'hEFFF, 0, 16'h0190);
        cyc(0, '0, 16'hEFFF, 1, 16'h0190);
        idle(2);
        cyc(0, 4'b0010, 16'hE010, 1, 16'h0190);
        idle(9);
        cyc(0, '0, 16'hE000, 1, 16'h0190);
        to_run();
        // Saturate the reset counter by re-requesting from BOOT.
        for (int i = 0; i < 260; i++) begin
            cyc(0, NS'(1 << (i % NS)), 16'h0000, 0, 16'h0000);
            idle(8);
        end
        @(posedge clk); #2;
        check("rst_count_sat", 32'(rst_count), 32'h0000_00FF);
        idle(2);
        // Reset in the middle of HOLD reloads the hold counter and clears state.
        cyc(0, 4'b0001, 16'h0000, 0, 16'h0000);
        idle(3);
        cyc(1, '0, 16'h0000, 0, 16'h0000);
        idle(10);
        to_run();
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic          r, w;
            logic [NS-1:0] q;
            logic [15:0]   p, a;
            int            k;
            r = ($urandom_range(0, 199) == 0);
            q = ($urandom_range(0, 11) == 0) ? NS'($urandom) : '0;
            k = $urandom_range(0, 7);
            p = (k == 0) ? 16'hFFFE : (k == 1) ? 16'(16'hE000 + $urandom_range(0, 16'h0FFF)) : 16'($urandom);
            w = ($urandom_range(0, 3) == 0);
            a = $urandom_range(0, 1) ? 16'h0190 : 16'($urandom);
            cyc(r, q, p, w, a);
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #2;
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
